matrix_operand_loader: RTL

Streaming front end for the dot-product datapath. Accepts one matrix element per beat over a valid/ready stream, fills operand matrix A (row-major) and then operand matrix B (row-major), and presents both as stable 2-D arrays to the combinational matrix multiplier. It holds the operands with `operands_valid` until the downstream side acknowledges the result, then re-arms for the next frame.

---
 rtl/matrix_pkg.sv | 32 +++
 rtl/matrix_index_counter.sv | 58 +++++
 rtl/matrix_operand_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix operand loader.
//   load_state_t : loader FSM states
//   idx_w        : index width for a dimension of n entries (minimum 1 bit)
//   max2         : larger of two dimensions
//   a_words      : beats in operand A (rows x cols)
//   b_words      : beats in operand B (rows x cols)
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } load_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int a_words(input int n_rows, input int n_cols);
    return n_rows * n_cols;
  endfunction

  function automatic int b_words(input int n_cols, input int m_cols);
    return n_cols * m_cols;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col index counter shared by the A and B load phases.
//   clk, rst : clock and synchronous active-high reset
//   clear    : return indices to 0 (phase change)
//   advance  : step to the next element
//   use_b    : 0 = wrap at A limits, 1 = wrap at B limits
//   row, col : current element position
//   wrap     : advance on the final element of the current phase
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int A_ROWS = 4,
  parameter int A_COLS = 4,
  parameter int B_ROWS = 4,
  parameter int B_COLS = 4,
  parameter int RW     = idx_w(max2(A_ROWS, B_ROWS)),
  parameter int CW     = idx_w(max2(A_COLS, B_COLS))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic          use_b,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          wrap
);

  localparam logic [RW-1:0] A_ROW_MAX = RW'(A_ROWS - 1);
  localparam logic [CW-1:0] A_COL_MAX = CW'(A_COLS - 1);
  localparam logic [RW-1:0] B_ROW_MAX = RW'(B_ROWS - 1);
  localparam logic [CW-1:0] B_COL_MAX = CW'(B_COLS - 1);

  logic [RW-1:0] row_max;
  logic [CW-1:0] col_max;
  logic          row_end;
  logic          col_end;

  assign row_max = use_b ? B_ROW_MAX : A_ROW_MAX;
  assign col_max = use_b ? B_COL_MAX : A_COL_MAX;
  assign row_end = (row == row_max);
  assign col_end = (col == col_max);
  assign wrap    = advance && row_end && col_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Streaming loader: fills operand A then operand B (both row-major) from a
// valid/ready element stream and holds them for the matrix multiplier.
//   clk, rst       : clock and synchronous active-high reset
//   in_data        : element payload
//   in_valid       : payload valid
//   in_ready       : loader can accept a beat
//   in_last        : final beat of a frame (last element of B)
//   memA, memB     : operand arrays, packed [row][col][bit]
//   operands_valid : A and B complete and stable (HOLD)
//   operands_ack   : consumer done; release operands
//   frame_error    : one-cycle pulse on a framing violation
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int M_COLS     = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DATA_WIDTH-1:0]                             in_data,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic                                              in_last,
  output logic [N_ROWS-1:0][N_COLS-1:0][DATA_WIDTH-1:0]     memA,
  output logic [N_COLS-1:0][M_COLS-1:0][DATA_WIDTH-1:0]     memB,
  output logic                                              operands_valid,
  input  logic                                              operands_ack,
  output logic                                              frame_error
);

  localparam int RW = idx_w(max2(N_ROWS, N_COLS));
  localparam int CW = idx_w(max2(N_COLS, M_COLS));

  load_state_t   state_q;
  load_state_t   state_d;
  logic          accept;
  logic          advance;
  logic          clear;
  logic          err_d;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          wrap;

  assign in_ready       = !rst && (state_q != HOLD);
  assign accept         = in_valid && in_ready;
  assign advance        = accept && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign operands_valid = (state_q == HOLD);

  matrix_index_counter #(
    .A_ROWS (N_ROWS),
    .A_COLS (N_COLS),
    .B_ROWS (N_COLS),
    .B_COLS (M_COLS),
    .RW     (RW),
    .CW     (CW)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .use_b   (state_q == LOAD_B),
    .row     (row),
    .col     (col),
    .wrap    (wrap)
  );

  // Any in_last that arrives before the final B slot is an early last,
  // including one on the final A slot.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          if (in_last) begin
            err_d   = 1'b1;
            clear   = 1'b1;
            state_d = LOAD_A;
          end else if (wrap) begin
            clear   = 1'b1;
            state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (wrap && in_last) begin
            clear   = 1'b1;
            state_d = HOLD;
          end else if (wrap) begin
            err_d   = 1'b1;
            clear   = 1'b1;
            state_d = DRAIN;
          end else if (in_last) begin
            err_d   = 1'b1;
            clear   = 1'b1;
            state_d = LOAD_A;
          end
        end
      end
      HOLD: begin
        if (operands_ack) begin
          clear   = 1'b1;
          state_d = LOAD_A;
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          clear   = 1'b1;
          state_d = LOAD_A;
        end
      end
      default: begin
        clear   = 1'b1;
        state_d = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_error <= err_d;
    end
  end

  // Storage: the beat lands at the counter's current position of the active phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      memA <= '0;
      memB <= '0;
    end else if (advance) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          if ((state_q == LOAD_A) && (row == RW'(r)) && (col == CW'(c)))
            memA[r][c] <= in_data;
        end
      end
      for (int r = 0; r < N_COLS; r++) begin
        for (int c = 0; c < M_COLS; c++) begin
          if ((state_q == LOAD_B) && (row == RW'(r)) && (col == CW'(c)))
            memB[r][c] <= in_data;
        end
      end
    end
  end

endmodule
